vga_tile_pipe: RTL and testbench
================================

Name: vga_tile_pipe

Overview:
Parametrised VGA scan engine for the snake display. It generates horizontal and vertical timing from configurable porch and sync widths. It fetches per-tile colour from the tile RAM with a configurable read latency and delays sync and blanking so they stay aligned with the returned data. It drives COLOR_W-bit RGB pins and also provides built-in test-pattern modes. It sits between the game-state tile RAM and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted sync level (0 = active-low)
COLOR_W, 1, bits per colour channel
TILE_SHIFT, 5, log2 of tile edge in pixels
ADDR_W, 10, tile RAM address width
RD_LAT, 1, tile RAM read latency in pixel ticks (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pix_en  in  1  pixel-tick enable; all state advances only when high
mode  in  2  00 tile RAM, 01 colour bars, 10 solid white, 11 black
rdata  in  3*COLOR_W  tile colour {R,G,B} from tile RAM
re  out  1  tile RAM read enable
raddr  out  ADDR_W  tile RAM address
R_out, G_out, B_out  out  COLOR_W each  pixel colour
HSync, VSync  out  1  sync outputs, polarity set by SYNC_POL
frame_start  out  1  one-clk pulse marking output pixel (0,0)

Behaviour:
- Reset (reset low, asynchronous): h/v counters = 0; delay line cleared to blank; RGB = 0; HSync/VSync = !SYNC_POL; re = 0; raddr = 0; frame_start = 0; latched mode = 00.
- Counters:
  - H_TOTAL = sum of the H_* parameters; V_TOTAL likewise.
  - hc increments on pix_en and wraps H_TOTAL-1 -> 0.
  - vc increments when hc wraps, and wraps V_TOTAL-1 -> 0.
  - Active region: hc < H_ACTIVE && vc < V_ACTIVE.
  - Sync asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync uses the same rule with the V_* parameters.
- Fetch (stage 0, registered):
  - TILES_X = H_ACTIVE >> TILE_SHIFT.
  - raddr = (vc>>TILE_SHIFT)*TILES_X + (hc>>TILE_SHIFT), truncated to ADDR_W. The multiply is by a constant, so a shift/add is acceptable.
  - re = pix_en && active && latched mode==00.
  - raddr holds its value when re is low.
- RAM contract: rdata for a read issued at tick t is valid at tick t+RD_LAT and stays stable until the next re.
- Delay line: active, hsync and vsync for each pixel pass through RD_LAT+1 pix_en-gated stages, so pins lag the counters by exactly RD_LAT+1 ticks.
- Output stage, registered and updated on pix_en only:
  - If not active: RGB = 0.
  - mode 00: RGB = rdata.
  - mode 01: eight equal vertical bars. Bar index comes from a per-line bar counter that steps every H_ACTIVE/8 pixels; bar n emits {n[2],n[1],n[0]}, each bit replicated to COLOR_W.
  - mode 10: all ones.
  - mode 11: zero.
- Mode change: mode is latched only when the counters wrap to (0,0), so a change mid-frame takes effect on the next frame with no tearing.
- frame_start: high for exactly one clk (the pix_en tick) when the output stage presents pixel (0,0).
- Boundaries:
  - pix_en low holds all state, including re = 0.
  - pix_en stuck high is legal.
  - Reset asserted mid-line restarts at (0,0), blank, with the pipeline flushed. The first frame_start occurs RD_LAT+1 ticks after reset is released with pix_en high.
  - The last tile (H_ACTIVE-1, V_ACTIVE-1) maps to TILES_X*TILES_Y-1; for the defaults that is 299.

Decomposition:
- vga_pkg:
  - mode enum (VGA_MODE_RAM, VGA_MODE_BARS, VGA_MODE_WHITE, VGA_MODE_BLACK).
  - Default 640x480@60 timing localparams.
  - Function computing H_TOTAL and V_TOTAL.
- Sub-module vga_sync_counter:
  - Inputs: clk, reset, pix_en, timing parameters.
  - Outputs: hc, vc, active, hsync_raw, vsync_raw, frame_wrap.
- Fetch, delay line and colour mux stay in vga_tile_pipe.

Test Plan:
- Reset, then pix_en high for one frame, defaults -> HSync low for exactly 96 ticks per line starting 656 ticks into the line; VSync low for 2 lines starting at line 490; 800x525 ticks per frame.
- mode=00, RAM model with RD_LAT=1 returning addr[2:0] -> raddr 0 at (0,0), 1 at col 32, 20 at row 32, 299 at (639,479). Pin colour equals the model data 2 ticks after the counter position; RGB=0 in blanking even with rdata=3'b111.
- RD_LAT=3, pix_en every 2nd clk -> latency 4 pix_en ticks; sync pins shifted by the same 4 ticks; re pulses coincide with pix_en only.
- mode switched 00->01 at line 100 -> current frame stays RAM data with re active. Next frame shows bars: 000 at col 0, 001 at col 80, 111 at col 560; re stays 0.
- reset pulsed low at hc=300, vc=200 -> outputs immediately at reset values. After release, frame_start fires after RD_LAT+1 ticks and the timing sequence matches a clean start.
- COLOR_W=4, mode=10 -> RGB = 4'hF for every active pixel and 0 in porches.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA tile pipeline.
package vga_pkg;

    // Output source selection, latched once per frame.
    typedef enum logic [1:0] {
        VGA_MODE_RAM   = 2'b00,
        VGA_MODE_BARS  = 2'b01,
        VGA_MODE_WHITE = 2'b10,
        VGA_MODE_BLACK = 2'b11
    } vga_mode_e;

    // Default 640x480@60 timing (25.175 MHz pixel clock).
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Side information that travels with each pixel while its tile read is in flight.
    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       first;
        vga_mode_e  mode;
        logic [2:0] bar;
    } pix_tag_t;

    // Total ticks per line (or lines per frame) from the four timing segments.
    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical scan counters with raw active, sync and frame-wrap decode.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HCW      = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VCW      = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    output logic [HCW-1:0] hc,
    output logic [VCW-1:0] vc,
    output logic           active,
    output logic           hsync_raw,
    output logic           vsync_raw,
    output logic           frame_wrap
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_START   = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END     = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] VS_START   = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END     = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HCW-1:0] hc_q, hc_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic           hWrap;
    logic           vWrap;

    assign hWrap = (hc_q == H_LAST);
    assign vWrap = (vc_q == V_LAST);

    // Advance the raster position by one pixel per tick, stepping the line at end of row.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (hWrap) begin
                hc_d = '0;
                vc_d = vWrap ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    // Counter registers restart at the top-left corner on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc         = hc_q;
    assign vc         = vc_q;
    assign active     = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
    assign hsync_raw  = (hc_q >= HS_START) && (hc_q <= HS_END);
    assign vsync_raw  = (vc_q >= VS_START) && (vc_q <= VS_END);
    assign frame_wrap = pix_en && hWrap && vWrap;

endmodule

// File: rtl/vga_tile_pipe.sv
// VGA scan engine: tile fetch, latency-matched sync/blank delay line and colour output.
module vga_tile_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_W    = 1,
    parameter int TILE_SHIFT = 5,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] rdata,
    output logic                 re,
    output logic [ADDR_W-1:0]    raddr,
    output logic [COLOR_W-1:0]   R_out,
    output logic [COLOR_W-1:0]   G_out,
    output logic [COLOR_W-1:0]   B_out,
    output logic                 HSync,
    output logic                 VSync,
    output logic                 frame_start
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int TILES_X = H_ACTIVE >> TILE_SHIFT;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [ADDR_W-1:0] TILES_X_A = ADDR_W'(TILES_X);
    localparam logic [HCW-1:0]    H_LAST    = HCW'(H_TOTAL - 1);
    localparam logic [BPW-1:0]    BAR_LAST  = BPW'(BAR_W - 1);

    logic [HCW-1:0]       hc;
    logic [VCW-1:0]       vc;
    logic                 active;
    logic                 hsyncRaw;
    logic                 vsyncRaw;
    logic                 frameWrap;
    logic                 lineEnd;

    vga_mode_e            modeLatch_q;
    logic [BPW-1:0]       barPix_q;
    logic [2:0]           barIdx_q;
    logic [ADDR_W-1:0]    tileAddr;
    logic                 re_d, re_q;
    logic [ADDR_W-1:0]    raddr_q;
    pix_tag_t             tagIn;
    pix_tag_t             tagOut;
    pix_tag_t             tagPipe_q [RD_LAT];
    logic [3*COLOR_W-1:0] colour_d, rgb_q;
    logic                 hsync_q, vsync_q, frameStart_q;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HCW      (HCW),
        .VCW      (VCW)
    ) uCounter (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hc         (hc),
        .vc         (vc),
        .active     (active),
        .hsync_raw  (hsyncRaw),
        .vsync_raw  (vsyncRaw),
        .frame_wrap (frameWrap)
    );

    assign lineEnd = (hc == H_LAST);

    // Mode only changes at the frame boundary so a frame is never drawn in two modes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            modeLatch_q <= VGA_MODE_RAM;
        end else if (frameWrap) begin
            modeLatch_q <= vga_mode_e'(mode);
        end
    end

    // Bar counter tracks hc so barIdx_q is the colour-bar index of the current pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            barPix_q <= '0;
            barIdx_q <= '0;
        end else if (pix_en) begin
            if (lineEnd) begin
                barPix_q <= '0;
                barIdx_q <= '0;
            end else if (barPix_q == BAR_LAST) begin
                barPix_q <= '0;
                barIdx_q <= barIdx_q + 3'd1;
            end else begin
                barPix_q <= barPix_q + 1'b1;
            end
        end
    end

    assign tileAddr = ADDR_W'(vc >> TILE_SHIFT) * TILES_X_A + ADDR_W'(hc >> TILE_SHIFT);
    assign re_d     = pix_en && active && (modeLatch_q == VGA_MODE_RAM);

    // Issue the tile read; the address is held between reads so the RAM output stays put.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            re_q    <= 1'b0;
            raddr_q <= '0;
        end else begin
            re_q <= re_d;
            if (re_d) begin
                raddr_q <= tileAddr;
            end
        end
    end

    assign re    = re_q;
    assign raddr = raddr_q;

    // Bundle the current pixel's timing and mode so it can follow its tile read.
    always_comb begin
        tagIn        = '0;
        tagIn.active = active;
        tagIn.hsync  = hsyncRaw;
        tagIn.vsync  = vsyncRaw;
        tagIn.first  = (hc == '0) && (vc == '0);
        tagIn.mode   = modeLatch_q;
        tagIn.bar    = barIdx_q;
    end

    // Delay line of RD_LAT stages; together with the output register it matches the RAM latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tagPipe_q[i] <= '0;
            end
        end else if (pix_en) begin
            tagPipe_q[0] <= tagIn;
            for (int i = 1; i < RD_LAT; i++) begin
                tagPipe_q[i] <= tagPipe_q[i-1];
            end
        end
    end

    assign tagOut = tagPipe_q[RD_LAT-1];

    // Pick the pixel colour for the pixel leaving the delay line; blanking forces black.
    always_comb begin
        colour_d = '0;
        if (tagOut.active) begin
            case (tagOut.mode)
                VGA_MODE_RAM:   colour_d = rdata;
                VGA_MODE_BARS:  colour_d = {{COLOR_W{tagOut.bar[2]}},
                                            {COLOR_W{tagOut.bar[1]}},
                                            {COLOR_W{tagOut.bar[0]}}};
                VGA_MODE_WHITE: colour_d = '1;
                default:        colour_d = '0;
            endcase
        end
    end

    // Output pins are registered and only move on a pixel tick; frame_start is a single-clock pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q        <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            frameStart_q <= 1'b0;
        end else begin
            frameStart_q <= pix_en && tagOut.first;
            if (pix_en) begin
                rgb_q   <= colour_d;
                hsync_q <= tagOut.hsync ? SYNC_POL : ~SYNC_POL;
                vsync_q <= tagOut.vsync ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign R_out       = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign G_out       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign B_out       = rgb_q[COLOR_W-1:0];
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_tile_pipe.sv
// Scoreboard bench for vga_tile_pipe using a reduced raster to keep runs short.
module tb_vga_tile_pipe;

    localparam int H_ACTIVE   = 64;
    localparam int H_FP       = 4;
    localparam int H_SYNC     = 8;
    localparam int H_BP       = 4;
    localparam int V_ACTIVE   = 24;
    localparam int V_FP       = 2;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 2;
    localparam bit SYNC_POL   = 1'b0;
    localparam int COLOR_W    = 2;
    localparam int TILE_SHIFT = 3;
    localparam int ADDR_W     = 6;
    localparam int RD_LAT     = 3;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME      = H_TOTAL * V_TOTAL;
    localparam int PW         = 3 * COLOR_W + 3;

    localparam logic [PW-1:0] BLANK = {{(3*COLOR_W){1'b0}}, ~SYNC_POL, ~SYNC_POL, 1'b0};

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 pix_en;
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] rdata;
    logic                 re;
    logic [ADDR_W-1:0]    raddr;
    logic [COLOR_W-1:0]   R_out, G_out, B_out;
    logic                 HSync, VSync, frame_start;
    logic [PW-1:0]        pinsObs;

    logic [3*COLOR_W-1:0] ramPipe [RD_LAT-1];

    int                   hM, vM;
    logic [1:0]           modeM;
    logic                 expRe;
    logic [ADDR_W-1:0]    expRaddr;
    logic [PW-1:0]        pinQ [$];
    logic [PW-1:0]        lastPins;
    int                   checkCount = 0;
    int                   failCount = 0;

    vga_tile_pipe #(
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .SYNC_POL   (SYNC_POL),
        .COLOR_W    (COLOR_W),
        .TILE_SHIFT (TILE_SHIFT),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .mode        (mode),
        .rdata       (rdata),
        .re          (re),
        .raddr       (raddr),
        .R_out       (R_out),
        .G_out       (G_out),
        .B_out       (B_out),
        .HSync       (HSync),
        .VSync       (VSync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    assign pinsObs = {R_out, G_out, B_out, HSync, VSync, frame_start};

    // Tile RAM content: a fixed scramble of the address so neighbouring tiles differ.
    function automatic logic [3*COLOR_W-1:0] ramData(input logic [ADDR_W-1:0] a);
        return a ^ 6'h2D;
    endfunction

    // Tile RAM timing: lookup of the held address, then RD_LAT-1 tick-gated stages.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT - 1; i++) ramPipe[i] <= '0;
        end else if (pix_en) begin
            ramPipe[0] <= ramData(raddr);
            for (int i = 1; i < RD_LAT - 1; i++) ramPipe[i] <= ramPipe[i-1];
        end
    end

    assign rdata = ramPipe[RD_LAT-2];

    function automatic logic [ADDR_W-1:0] tileOf(input int h, input int v);
        return ADDR_W'((v >> TILE_SHIFT) * (H_ACTIVE >> TILE_SHIFT) + (h >> TILE_SHIFT));
    endfunction

    // Expected pins {R,G,B,HSync,VSync,frame_start} for raster position (h,v) in mode m.
    function automatic logic [PW-1:0] expectPins(input int h, input int v, input logic [1:0] m);
        logic                 act, hsA, vsA, fs;
        logic [2:0]           bar;
        logic [3*COLOR_W-1:0] rgb;
        act = (h < H_ACTIVE) && (v < V_ACTIVE);
        hsA = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
        vsA = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
        fs  = (h == 0) && (v == 0);
        bar = 3'(h / (H_ACTIVE / 8));
        rgb = '0;
        if (act) begin
            case (m)
                2'b00:   rgb = ramData(tileOf(h, v));
                2'b01:   rgb = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
                2'b10:   rgb = '1;
                default: rgb = '0;
            endcase
        end
        return {rgb, hsA ? SYNC_POL : ~SYNC_POL, vsA ? SYNC_POL : ~SYNC_POL, fs};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        hM       = 0;
        vM       = 0;
        modeM    = 2'b00;
        expRe    = 1'b0;
        expRaddr = '0;
        lastPins = BLANK;
        pinQ.delete();
        for (int i = 0; i < RD_LAT; i++) pinQ.push_back(BLANK);
    endtask

    // One clock: drive pix_en, update the model on a tick, then compare everything.
    task automatic applyStimulus(input logic pe);
        logic [PW-1:0] exp;
        logic          act;
        @(negedge clk);
        pix_en = pe;
        @(posedge clk);
        if (pe) begin
            act   = (hM < H_ACTIVE) && (vM < V_ACTIVE);
            expRe = act && (modeM == 2'b00);
            if (expRe) expRaddr = tileOf(hM, vM);
            pinQ.push_back(expectPins(hM, vM, modeM));
            exp      = pinQ.pop_front();
            lastPins = exp;
            if (hM == H_TOTAL - 1) begin
                hM = 0;
                if (vM == V_TOTAL - 1) begin
                    vM    = 0;
                    modeM = mode;
                end else begin
                    vM++;
                end
            end else begin
                hM++;
            end
        end else begin
            expRe = 1'b0;
            exp   = {lastPins[PW-1:1], 1'b0};
        end
        #1;
        checkOutput("re", {31'b0, re}, {31'b0, expRe});
        checkOutput("raddr", 32'(raddr), 32'(expRaddr));
        if (pe) checkOutput("pins", 32'(pinsObs), 32'(exp));
        else    checkOutput("pins_hold", 32'(pinsObs), 32'(exp));
    endtask

    // Run n pixel ticks: pattern 0 = every clock, 1 = random, 2 = every second clock.
    task automatic runPix(input int n, input int pattern);
        int   done;
        logic pe;
        logic phase;
        done  = 0;
        phase = 1'b0;
        while (done < n) begin
            case (pattern)
                0:       pe = 1'b1;
                1:       pe = ($urandom_range(0, 1) == 1);
                default: begin pe = phase; phase = ~phase; end
            endcase
            applyStimulus(pe);
            if (pe) done++;
        end
    endtask

    // Mid-line reset: outputs must drop to reset values at once, then restart from (0,0).
    task automatic applyReset();
        @(negedge clk);
        reset  = 1'b0;
        pix_en = 1'b1;
        #1;
        checkOutput("rst_pins", 32'(pinsObs), 32'(BLANK));
        checkOutput("rst_re", {31'b0, re}, 32'd0);
        checkOutput("rst_raddr", 32'(raddr), 32'd0);
        resetModel();
        repeat (2) @(negedge clk);
        pix_en = 1'b0;
        reset  = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        pix_en = 1'b0;
        mode   = 2'b00;
        resetModel();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_pins", 32'(pinsObs), 32'(BLANK));
        checkOutput("reset_re", {31'b0, re}, 32'd0);
        checkOutput("reset_raddr", 32'(raddr), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] frame 1: tile RAM, pix_en stuck high; bars requested at line 10");
        runPix(H_TOTAL * 10, 0);
        mode = 2'b01;
        runPix(FRAME - H_TOTAL * 10, 0);

        $display("[TB] frame 2: colour bars, random pix_en; white requested mid-frame");
        runPix(H_TOTAL * 12, 1);
        mode = 2'b10;
        runPix(FRAME - H_TOTAL * 12, 1);

        $display("[TB] frame 3: solid white, pix_en every second clock; black requested");
        runPix(H_TOTAL * 5, 2);
        mode = 2'b11;
        runPix(FRAME - H_TOTAL * 5, 2);

        $display("[TB] frame 4: black, then reset mid-line");
        runPix(H_TOTAL * 7 + 37, 1);
        mode = 2'b00;
        applyReset();

        $display("[TB] restart: tile RAM after reset, mixed pix_en");
        runPix(H_TOTAL * 3, 0);
        runPix(FRAME, 1);
        runPix(H_TOTAL * 4, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
        $finish;
    end

endmodule
